// File: rtl/decode_stage.sv
// RV32/RV64 registered decode stage: field split, immediate build, opcode
// classification and illegal-encoding detection behind a valid/ready pipe.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_EMPTY | no decoded entry held, out_valid low
// S_ONE   | entry 0 valid and driving out_*
// S_TWO   | entry 0 driving out_*, entry 1 queued behind it (SKID only)

package lib_pkg;
    typedef enum logic [3:0] {
        OP_LUI     = 4'd0,
        OP_AUIPC   = 4'd1,
        OP_JAL     = 4'd2,
        OP_JALR    = 4'd3,
        OP_BRANCH  = 4'd4,
        OP_LOAD    = 4'd5,
        OP_STORE   = 4'd6,
        OP_OPIMM   = 4'd7,
        OP_OP      = 4'd8,
        OP_MISCMEM = 4'd9,
        OP_SYSTEM  = 4'd10
    } op_type_t;
endpackage

module decode_stage #(
    parameter int XLEN  = 32,
    parameter int M_EXT = 0,
    parameter int SKID  = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [3:0]      out_op_type,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [4:0]      out_rd,
    output logic [2:0]      out_funct3,
    output logic [6:0]      out_funct7,
    output logic [XLEN-1:0] out_imm,
    output logic            out_is_word,
    output logic            out_illegal
);
    import lib_pkg::*;

    localparam bit RV64 = (XLEN == 64);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        op_type_t        op;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [2:0]      funct3;
        logic [6:0]      funct7;
        logic [XLEN-1:0] imm;
        logic            is_word;
        logic            illegal;
    } entry_t;

    typedef enum logic [1:0] {S_EMPTY, S_ONE, S_TWO} state_t;

    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        logic [63:0] t;
        t = {{32{v[31]}}, v};
        return t[XLEN-1:0];
    endfunction

    state_t      state_q, state_d;
    entry_t      e0_q, e0_d, e1_q, e1_d;
    logic        in_ready_q, in_ready_d;
    entry_t      dec;
    logic        accept, xfer;

    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [5:0]  f6;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    assign opc   = in_instr[6:0];
    assign f3    = in_instr[14:12];
    assign f7    = in_instr[31:25];
    assign f6    = in_instr[31:26];
    assign imm_i = {{20{in_instr[31]}}, in_instr[31:20]};
    assign imm_s = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
    assign imm_b = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
    assign imm_u = {in_instr[31:12], 12'b0};
    assign imm_j = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};

    // Combinational decode of the offered instruction.
    always_comb begin
        logic [31:0] imm32;
        logic        ill;
        logic        word;
        op_type_t    op;
        imm32 = '0;
        ill   = 1'b0;
        word  = 1'b0;
        op    = OP_SYSTEM;
        case (opc)
            7'b0110111: begin op = OP_LUI;    imm32 = imm_u; end
            7'b0010111: begin op = OP_AUIPC;  imm32 = imm_u; end
            7'b1101111: begin op = OP_JAL;    imm32 = imm_j; end
            7'b1100111: begin op = OP_JALR;   imm32 = imm_i; ill = (f3 != 3'b000); end
            7'b1100011: begin
                op = OP_BRANCH; imm32 = imm_b;
                ill = (f3 == 3'b010) || (f3 == 3'b011);
            end
            7'b0000011: begin
                op = OP_LOAD; imm32 = imm_i;
                ill = (f3 == 3'b111) || (!RV64 && ((f3 == 3'b011) || (f3 == 3'b110)));
            end
            7'b0100011: begin
                op = OP_STORE; imm32 = imm_s;
                ill = f3[2] || (!RV64 && (f3 == 3'b011));
            end
            7'b0010011: begin
                op = OP_OPIMM; imm32 = imm_i;
                if (f3 == 3'b001)
                    ill = RV64 ? (f6 != 6'b0) : (f7 != 7'b0);
                else if (f3 == 3'b101)
                    ill = RV64 ? !((f6 == 6'b0) || (f6 == 6'b010000))
                               : !((f7 == 7'b0) || (f7 == 7'b0100000));
            end
            7'b0110011: begin
                op = OP_OP;
                ill = !((f7 == 7'b0000000) ||
                        ((f7 == 7'b0100000) && ((f3 == 3'b000) || (f3 == 3'b101))) ||
                        ((f7 == 7'b0000001) && (M_EXT != 0)));
            end
            7'b0001111: op = OP_MISCMEM;
            7'b1110011: op = OP_SYSTEM;
            7'b0011011: begin
                op = OP_OPIMM; word = 1'b1; imm32 = imm_i;
                ill = !RV64 || !((f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b101));
            end
            7'b0111011: begin
                op = OP_OP; word = 1'b1;
                ill = !RV64 || !((f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b101)) ||
                      ((f7 == 7'b0000001) && (M_EXT == 0));
            end
            default: ill = 1'b1;
        endcase
        // Illegal entries are reported as SYSTEM with no immediate so execute can trap uniformly.
        if (ill) begin
            op    = OP_SYSTEM;
            imm32 = '0;
            word  = 1'b0;
        end
        dec         = '0;
        dec.pc      = in_pc;
        dec.op      = op;
        dec.rs1     = in_instr[19:15];
        dec.rs2     = in_instr[24:20];
        dec.rd      = in_instr[11:7];
        dec.funct3  = f3;
        dec.funct7  = f7;
        dec.imm     = sext32(imm32);
        dec.is_word = word;
        dec.illegal = ill;
    end

    assign out_valid = (state_q != S_EMPTY);
    assign in_ready  = (SKID != 0) ? in_ready_q : ((state_q == S_EMPTY) || out_ready);
    assign accept    = in_valid && in_ready;
    assign xfer      = out_valid && out_ready;

    // Buffer occupancy and entry movement; flush overrides everything.
    always_comb begin
        state_d = state_q;
        e0_d    = e0_q;
        e1_d    = e1_q;
        case (state_q)
            S_EMPTY: if (accept) begin e0_d = dec; state_d = S_ONE; end
            S_ONE: begin
                if (accept && xfer) e0_d = dec;
                else if (accept) begin e1_d = dec; state_d = S_TWO; end
                else if (xfer) state_d = S_EMPTY;
            end
            S_TWO: if (xfer) begin e0_d = e1_q; state_d = S_ONE; end
            default: state_d = S_EMPTY;
        endcase
        if (flush) begin
            state_d = S_EMPTY;
            e0_d    = e0_q;
            e1_d    = e1_q;
        end
        in_ready_d = (state_d != S_TWO);
    end

    // State and payload registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_EMPTY;
            e0_q       <= '0;
            e1_q       <= '0;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            e0_q       <= e0_d;
            e1_q       <= e1_d;
            in_ready_q <= in_ready_d;
        end
    end

    assign out_pc      = e0_q.pc;
    assign out_op_type = e0_q.op;
    assign out_rs1     = e0_q.rs1;
    assign out_rs2     = e0_q.rs2;
    assign out_rd      = e0_q.rd;
    assign out_funct3  = e0_q.funct3;
    assign out_funct7  = e0_q.funct7;
    assign out_imm     = e0_q.imm;
    assign out_is_word = e0_q.is_word;
    assign out_illegal = e0_q.illegal;

endmodule
